md_reset_sequencer: RTL
=======================

# md_reset_sequencer

Board-level reset and clock-enable scheduler for `md_board`. It turns one external active-low reset into an ordered release of the VDP/YM, 68000 and Z80 resets, and latches the cartridge M3 mode strap at release. It also generates the free-running 68000 and Z80 clock enables from MCLK. It sits between the board reset pin and the CPU/VDP cores, replacing ad-hoc direct wiring of `ext_reset`.

## Interface
Parameters:
- HOLD_CYCLES, 256, MCLK cycles after reset deassertion before VDP/YM release (1..65535)
- M68K_DELAY, 128, MCLK cycles from VDP release to 68000 release (1..65535)
- SOFT_CYCLES, 64, MCLK cycles the CPUs are held during a soft reset (1..65535)
- DIV68K, 7, MCLK divisor for `cen68k` (2..15)
- DIVZ80, 15, MCLK divisor for `cenz80` (2..15)

Ports (one clock; reset is asynchronous and active-low):
- MCLK  in  1  master clock, all state on rising edge
- ext_reset_n  in  1  asynchronous active-low board reset
- M3  in  1  cartridge mode strap, sampled once at VDP release
- z80_reset_ctl  in  1  68000-written Z80 reset register ($A11200 bit 0); 1 = run
- soft_reset_req  in  1  front-panel reset button, synchronous to MCLK
- vdp_reset_n  out  1  VDP reset, active-low
- ym_reset_n  out  1  YM2612 reset, active-low, identical timing to vdp_reset_n
- m68k_reset_n  out  1  68000 reset, active-low
- z80_reset_n  out  1  Z80 reset, active-low
- m3_latched  out  1  latched M3
- cen68k  out  1  one-MCLK-wide 68000 clock enable
- cenz80  out  1  one-MCLK-wide Z80 clock enable
- seq_state  out  2  current state: 0 WAIT, 1 VDP, 2 RUN, 3 SOFT
- sys_ready  out  1  high while in RUN

## Operation
- Reset (`ext_reset_n`=0, asynchronous): state WAIT, 16-bit counter 0, dividers 0. All `*_reset_n`, `m3_latched`, `cen*`, and `sys_ready` are 0.
- WAIT: the counter increments each edge. On the edge where counter == HOLD_CYCLES-1, the block moves to VDP, clears the counter, and registers `vdp_reset_n`=`ym_reset_n`=1 and `m3_latched`=M3.
- VDP: the counter increments. On counter == M68K_DELAY-1, the block moves to RUN and registers `m68k_reset_n`=1 and `sys_ready`=1.
- RUN: `z80_reset_n` is registered from `z80_reset_ctl` every edge. In every other state `z80_reset_n` is 0.
- SOFT: entered from RUN on a rising edge of `soft_reset_req`, detected against a registered previous value. On entry, `m68k_reset_n`, `z80_reset_n` and `sys_ready` go to 0 and the counter clears. VDP, YM and `m3_latched` are unchanged. On counter == SOFT_CYCLES-1 the block moves to VDP; the normal M68K_DELAY release then follows.
- `soft_reset_req` edges in WAIT, VDP or SOFT are ignored. A level held high does not retrigger.
- Dividers: free-running 4-bit counters, 0..DIV-1, wrapping to 0. `cen68k` is 1 on the edge after the counter reaches DIV68K-1; `cenz80` likewise. They run in all states once reset is deasserted and are never gated by the sequence.
- `m3_latched` changes only on WAIT→VDP.

## Timing
- Count rising MCLK edges from the first edge with `ext_reset_n`=1 as edge 1.
- `vdp_reset_n` and `ym_reset_n` rise after edge HOLD_CYCLES. `m68k_reset_n` rises after edge HOLD_CYCLES+M68K_DELAY.
- Z80 release lags a change on `z80_reset_ctl` by 1 edge.
- Soft reset: `m68k_reset_n` falls 2 edges after `soft_reset_req` rises (1 edge for edge detection, 1 for transition). It rises again SOFT_CYCLES+M68K_DELAY edges after SOFT entry.
- `cen68k` first pulses after edge DIV68K, then every DIV68K edges; `cenz80` likewise with DIVZ80.
- Reset asserted mid-sequence, in any state, returns everything to reset values immediately, without waiting for MCLK.

## Configuration
- MD_SOFT_RESET_EN defined: soft-reset path and SOFT state are present as described.
- MD_SOFT_RESET_EN undefined:
  - `soft_reset_req` is ignored and SOFT is unreachable.
  - `seq_state` never reads 3.
  - No edge-detect register is built.

## Test plan
- Default params, `ext_reset_n` low 10 edges then high. Required:
  - `vdp_reset_n` rises after edge 256.
  - `m68k_reset_n` rises after edge 384.
  - `sys_ready` becomes 1 at the same edge as `m68k_reset_n`.
- M3=1 before release, M3=0 after edge 256. Required: `m3_latched` stays 1.
- In RUN, toggle `z80_reset_ctl` 0→1→0. Required: `z80_reset_n` follows with 1-edge lag. Also drive `z80_reset_ctl`=1 during WAIT; `z80_reset_n` must stay 0.
- In RUN, pulse `soft_reset_req` for 3 edges, with MD_SOFT_RESET_EN defined. Required:
  - `m68k_reset_n` is 0 two edges later.
  - `vdp_reset_n` stays 1.
  - `m68k_reset_n` returns to 1 after 64+128 edges.
  - Holding the request high does not retrigger.
  - With the macro undefined, there is no change.
- Assert `ext_reset_n` low midway through VDP state. Required: all outputs go to 0 asynchronously, and the full 256/384 sequence restarts.
- Count edges between `cen68k` pulses and between `cenz80` pulses over 1000 edges. Required: 7 and 15 exactly, with every pulse one edge wide.

Source files
------------

// File: rtl/md_reset_sequencer.sv
// -----------------------------------------------------------------------------
// md_reset_sequencer
//   Board-level reset and clock-enable scheduler for md_board.
//   Turns the external active-low reset into an ordered release of
//   VDP/YM -> 68000 -> Z80, latches the cartridge M3 strap at VDP release,
//   and generates the free-running 68000 / Z80 clock enables from MCLK.
//
//   Build option:
//     MD_SOFT_RESET_EN  - when defined, a rising edge on soft_reset_req while
//                         running holds both CPUs in reset for SOFT_CYCLES and
//                         then replays the 68000 release delay. When undefined
//                         the request input is ignored and SOFT never occurs.
// -----------------------------------------------------------------------------
module md_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 256,  // MCLK edges before VDP/YM release
  parameter int unsigned M68K_DELAY  = 128,  // VDP release -> 68000 release
  parameter int unsigned SOFT_CYCLES = 64,   // CPU hold time during soft reset
  parameter int unsigned DIV68K      = 7,    // MCLK divisor for cen68k
  parameter int unsigned DIVZ80      = 15    // MCLK divisor for cenz80
) (
  input  logic       MCLK,
  input  logic       ext_reset_n,
  input  logic       M3,
  input  logic       z80_reset_ctl,
  input  logic       soft_reset_req,
  output logic       vdp_reset_n,
  output logic       ym_reset_n,
  output logic       m68k_reset_n,
  output logic       z80_reset_n,
  output logic       m3_latched,
  output logic       cen68k,
  output logic       cenz80,
  output logic [1:0] seq_state,
  output logic       sys_ready
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_VDP  = 2'd1,
    ST_RUN  = 2'd2,
    ST_SOFT = 2'd3
  } seq_state_t;

  // Terminal counts: the transition happens on the edge where the counter
  // already holds the last value, so a phase lasts exactly N edges.
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] M68K_LAST   = 16'(M68K_DELAY - 1);
  localparam logic [15:0] SOFT_LAST   = 16'(SOFT_CYCLES - 1);
  localparam logic [3:0]  DIV68K_LAST = 4'(DIV68K - 1);
  localparam logic [3:0]  DIVZ80_LAST = 4'(DIVZ80 - 1);

  // Sequencer state and its registered outputs
  seq_state_t  state;
  seq_state_t  state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        vdp_rel;
  logic        vdp_rel_nxt;
  logic        m68k_rel;
  logic        m68k_rel_nxt;
  logic        z80_rel;
  logic        z80_rel_nxt;
  logic        m3_q;
  logic        m3_nxt;
  logic        ready_q;
  logic        ready_nxt;

  // Soft-reset trigger (one-cycle pulse, already edge-detected)
  logic        soft_trig;

  // Clock-enable dividers
  logic [3:0]  div68k_cnt;
  logic [3:0]  divz80_cnt;
  logic        cen68k_q;
  logic        cenz80_q;

`ifdef MD_SOFT_RESET_EN
  // ---- stage p1/p2: request history for rising-edge detection ----
  logic req_p1;
  logic req_p2;

  // Register the button twice so a level held high produces a single pulse.
  always_ff @(posedge MCLK or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      req_p1 <= 1'b0;
      req_p2 <= 1'b0;
    end else begin
      req_p1 <= soft_reset_req;
      req_p2 <= req_p1;
    end
  end

  assign soft_trig = req_p1 & ~req_p2;
`else
  // Without the soft-reset path the button has no effect at all.
  logic soft_req_unused;
  assign soft_req_unused = soft_reset_req;
  assign soft_trig       = 1'b0;
`endif

  // ---- sequencer: state and release flags ----

  // State register plus the registered reset-release outputs.
  always_ff @(posedge MCLK or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state    <= ST_WAIT;
      cnt      <= 16'd0;
      vdp_rel  <= 1'b0;
      m68k_rel <= 1'b0;
      z80_rel  <= 1'b0;
      m3_q     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      vdp_rel  <= vdp_rel_nxt;
      m68k_rel <= m68k_rel_nxt;
      z80_rel  <= z80_rel_nxt;
      m3_q     <= m3_nxt;
      ready_q  <= ready_nxt;
    end
  end

  // Next-state logic: count through each phase, release resets in order.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 16'd1;
    vdp_rel_nxt  = vdp_rel;
    m68k_rel_nxt = m68k_rel;
    m3_nxt       = m3_q;
    ready_nxt    = ready_q;
    // The Z80 is only allowed out of reset while the system is running.
    z80_rel_nxt  = 1'b0;

    case (state)
      ST_WAIT: begin
        if (cnt == HOLD_LAST) begin
          state_nxt   = ST_VDP;
          cnt_nxt     = 16'd0;
          vdp_rel_nxt = 1'b1;
          // The strap is captured once, at the moment the VDP comes alive.
          m3_nxt      = M3;
        end
      end

      ST_VDP: begin
        if (cnt == M68K_LAST) begin
          state_nxt    = ST_RUN;
          cnt_nxt      = 16'd0;
          m68k_rel_nxt = 1'b1;
          ready_nxt    = 1'b1;
        end
      end

      ST_RUN: begin
        cnt_nxt = 16'd0;
        if (soft_trig) begin
          // Drop both CPUs; VDP/YM and the latched strap stay as they are.
          state_nxt    = ST_SOFT;
          m68k_rel_nxt = 1'b0;
          ready_nxt    = 1'b0;
        end else begin
          z80_rel_nxt = z80_reset_ctl;
        end
      end

`ifdef MD_SOFT_RESET_EN
      ST_SOFT: begin
        if (cnt == SOFT_LAST) begin
          // Re-enter VDP so the normal 68000 release delay is replayed.
          state_nxt = ST_VDP;
          cnt_nxt   = 16'd0;
        end
      end
`endif

      default: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // ---- clock-enable dividers ----

  // Free-running dividers; each enable is one MCLK wide, every DIV edges.
  always_ff @(posedge MCLK or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      div68k_cnt <= 4'd0;
      divz80_cnt <= 4'd0;
      cen68k_q   <= 1'b0;
      cenz80_q   <= 1'b0;
    end else begin
      div68k_cnt <= (div68k_cnt == DIV68K_LAST) ? 4'd0 : div68k_cnt + 4'd1;
      divz80_cnt <= (divz80_cnt == DIVZ80_LAST) ? 4'd0 : divz80_cnt + 4'd1;
      cen68k_q   <= (div68k_cnt == DIV68K_LAST);
      cenz80_q   <= (divz80_cnt == DIVZ80_LAST);
    end
  end

  // ---- outputs ----
  assign vdp_reset_n  = vdp_rel;
  assign ym_reset_n   = vdp_rel;
  assign m68k_reset_n = m68k_rel;
  assign z80_reset_n  = z80_rel;
  assign m3_latched   = m3_q;
  assign sys_ready    = ready_q;
  assign seq_state    = state;
  assign cen68k       = cen68k_q;
  assign cenz80       = cenz80_q;

endmodule
